// File: rtl/tri_wave_monitor.sv
// tri_wave_monitor: checks an incoming triangle-counter sample stream
// (0 -> max -> 0 in unit steps), counts peaks, measures the trough-to-trough
// period, flags step errors (sticky) and drives a PWM view of the last sample.
// Optional PWM logic is built only when TRI_WAVE_MONITOR_PWM_EN is defined;
// otherwise pwm_out is tied low.
module tri_wave_monitor #(
  parameter int WIDTH    = 4,
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [WIDTH-1:0]    sample,
  input  logic [WIDTH-1:0]    max,
  output logic                dir_up,
  output logic [7:0]          peak_count,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                step_err,
  output logic                pwm_out
);

  typedef enum logic [1:0] {INIT, RISE, FALL} state_t;

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      prev;
  logic [PERIOD_W-1:0]   per_cnt, per_cnt_nxt;
  logic                  first_pend, first_pend_nxt;
  logic [7:0]            peak_nxt;
  logic [PERIOD_W-1:0]   period_nxt;
  logic                  pv_nxt;
  logic                  err_nxt;

  logic [WIDTH:0]        prev_inc;
  logic [PERIOD_W-1:0]   per_inc;
  logic                  rise_ok;
  logic                  fall_ok;

  assign prev_inc = {1'b0, prev} + (WIDTH+1)'(1);
  assign per_inc  = (&per_cnt) ? per_cnt : per_cnt + PERIOD_W'(1);
  assign rise_ok  = (state == RISE) && ({1'b0, sample} == prev_inc) && (sample <= max);
  assign fall_ok  = (state == FALL) && (prev != '0) && (sample == prev - WIDTH'(1))
                    && (sample <= max);
  assign dir_up   = (state == RISE);

  // State and measurement registers; everything holds unless a sample is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      prev         <= '0;
      per_cnt      <= '0;
      first_pend   <= 1'b1;
      peak_count   <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      step_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      per_cnt      <= per_cnt_nxt;
      first_pend   <= first_pend_nxt;
      peak_count   <= peak_nxt;
      period       <= period_nxt;
      period_valid <= pv_nxt;
      step_err     <= err_nxt;
      if (sample_valid) prev <= sample;
    end
  end

  // Next-state, event and counter decode for one accepted sample.
  always_comb begin
    state_nxt      = state;
    per_cnt_nxt    = per_cnt;
    first_pend_nxt = first_pend;
    peak_nxt       = peak_count;
    period_nxt     = period;
    pv_nxt         = 1'b0;
    err_nxt        = step_err;
    if (sample_valid) begin
      if (state == INIT) begin
        per_cnt_nxt    = '0;
        first_pend_nxt = 1'b1;
        state_nxt      = ((sample == max) && (max != '0)) ? FALL : RISE;
      end else if (max == '0) begin
        // Degenerate waveform: only zeros are legal and the block parks in RISE.
        state_nxt = RISE;
        if (sample != '0) begin
          err_nxt        = 1'b1;
          per_cnt_nxt    = '0;
          first_pend_nxt = 1'b1;
        end else begin
          per_cnt_nxt = per_inc;
        end
      end else if (rise_ok && (sample == max)) begin
        peak_nxt    = peak_count + 8'd1;
        per_cnt_nxt = per_inc;
        state_nxt   = FALL;
      end else if (fall_ok && (sample == '0)) begin
        if (!first_pend) begin
          period_nxt = per_inc;
          pv_nxt     = 1'b1;
        end
        first_pend_nxt = 1'b0;
        per_cnt_nxt    = '0;
        state_nxt      = RISE;
      end else if (rise_ok || fall_ok) begin
        per_cnt_nxt = per_inc;
      end else begin
        err_nxt        = 1'b1;
        per_cnt_nxt    = '0;
        first_pend_nxt = 1'b1;
        if (sample == max)        state_nxt = FALL;
        else if (sample == '0)    state_nxt = RISE;
        else if (sample > prev)   state_nxt = RISE;
        else                      state_nxt = FALL;
      end
    end
  end

`ifdef TRI_WAVE_MONITOR_PWM_EN
  logic [WIDTH-1:0] pwm_cnt;
  logic [WIDTH-1:0] last_sample;

  // Free-running PWM counter compared against the most recent accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt     <= '0;
      last_sample <= '0;
      pwm_out     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + WIDTH'(1);
      if (sample_valid) last_sample <= sample;
      pwm_out <= (pwm_cnt < last_sample);
    end
  end
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_tri_wave_monitor.sv
// Self-checking bench for tri_wave_monitor: directed scenarios followed by a
// randomized triangle stream with glitches, gaps, max changes and resets,
// all compared against a behavioural model of the sample-checking rules.
module tb_tri_wave_monitor;

  localparam int WIDTH    = 4;
  localparam int PERIOD_W = 8;
  localparam int PMAX     = (1 << PERIOD_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                sample_valid = 1'b0;
  logic [WIDTH-1:0]    sample = '0;
  logic [WIDTH-1:0]    max = '0;
  logic                dir_up;
  logic [7:0]          peak_count;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                step_err;
  logic                pwm_out;

  tri_wave_monitor #(.WIDTH(WIDTH), .PERIOD_W(PERIOD_W)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample), .max(max),
    .dir_up(dir_up), .peak_count(peak_count), .period(period),
    .period_valid(period_valid), .step_err(step_err), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase is the slope of the waveform (+1 rising,
  // -1 falling, 0 = no sample seen yet since reset).
  int  m_phase, m_prev, m_per, m_peaks, m_period, m_pv, m_err;
  bit  m_fresh;
  int  pv_seen, pwm_hi;

  task automatic model(input bit r, input bit v, input int s, input int mx);
    int nxt_per;
    m_pv = 0;
    nxt_per = (m_per + 1 > PMAX) ? PMAX : m_per + 1;
    if (r) begin
      m_phase = 0; m_prev = 0; m_per = 0; m_peaks = 0; m_period = 0;
      m_err = 0; m_fresh = 1;
    end else if (v) begin
      if (m_phase == 0) begin
        m_per = 0; m_fresh = 1;
        m_phase = (s == mx && mx != 0) ? -1 : 1;
      end else if (mx == 0) begin
        m_phase = 1;
        if (s != 0) begin m_err = 1; m_per = 0; m_fresh = 1; end
        else m_per = nxt_per;
      end else if (s == m_prev + m_phase && s <= mx) begin
        if (m_phase == 1 && s == mx) begin
          m_peaks = (m_peaks + 1) % 256; m_phase = -1; m_per = nxt_per;
        end else if (m_phase == -1 && s == 0) begin
          if (!m_fresh) begin m_period = nxt_per; m_pv = 1; end
          m_fresh = 0; m_per = 0; m_phase = 1;
        end else m_per = nxt_per;
      end else begin
        m_err = 1; m_per = 0; m_fresh = 1;
        if (s == mx)          m_phase = -1;
        else if (s == 0)      m_phase = 1;
        else if (s > m_prev)  m_phase = 1;
        else                  m_phase = -1;
      end
      m_prev = s;
    end
  endtask

  // Drive one cycle, let the clock edge take it, then compare all outputs.
  task automatic step(input bit r, input bit v, input int s, input int mx);
    rst = r; sample_valid = v; sample = WIDTH'(s); max = WIDTH'(mx);
    @(posedge clk);
    #1;
    model(r, v, s, mx);
    check("dir_up",       32'(dir_up),       32'(m_phase == 1));
    check("peak_count",   32'(peak_count),   32'(m_peaks));
    check("period",       32'(period),       32'(m_period));
    check("period_valid", 32'(period_valid), 32'(m_pv));
    check("step_err",     32'(step_err),     32'(m_err));
    if (period_valid) pv_seen++;
    if (pwm_out) pwm_hi++;
  endtask

  task automatic feed(input int mx, input int gap, input int vals[$]);
    foreach (vals[i]) begin
      step(0, 1, vals[i], mx);
      repeat (gap) step(0, 0, $urandom_range(15), mx);
    end
  endtask

  task automatic pwm_test(input int s);
    int exp_hi;
    step(1, 0, 0, 0);
    step(0, 1, s, 15);
    pwm_hi = 0;
    repeat (16) step(0, 0, 0, 15);
`ifdef TRI_WAVE_MONITOR_PWM_EN
    exp_hi = s;
`else
    exp_hi = 0;
`endif
    check("pwm_duty", 32'(pwm_hi), 32'(exp_hi));
  endtask

  int nominal[$] = '{0,1,2,3,2,1,0,1,2,3,2,1,0};

  initial begin
    int g, gd, mx;
    m_phase = 0; m_prev = 0; m_per = 0; m_peaks = 0; m_period = 0;
    m_pv = 0; m_err = 0; m_fresh = 1; pv_seen = 0; pwm_hi = 0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_peak", 32'(peak_count), 32'd0);

    // Nominal max=3 stream
    pv_seen = 0;
    feed(3, 0, '{0,1,2,3});
    check("nom_peak1", 32'(peak_count), 32'd1);
    feed(3, 0, '{2,1,0,1,2,3});
    check("nom_peak2", 32'(peak_count), 32'd2);
    check("nom_nopv_first", 32'(pv_seen), 32'd0);
    feed(3, 0, '{2,1,0});
    check("nom_period", 32'(period), 32'd6);
    check("nom_pv_pulse", 32'(period_valid), 32'd1);
    check("nom_pv_count", 32'(pv_seen), 32'd1);
    check("nom_err", 32'(step_err), 32'd0);

    // Same stream with 3 idle cycles between samples
    step(1, 0, 0, 0);
    pv_seen = 0;
    feed(3, 3, nominal);
    check("gap_peak", 32'(peak_count), 32'd2);
    check("gap_period", 32'(period), 32'd6);
    check("gap_pv_count", 32'(pv_seen), 32'd1);

    // Step error and resync
    step(1, 0, 0, 0);
    feed(5, 0, '{0,1,3});
    check("se_err", 32'(step_err), 32'd1);
    check("se_dir", 32'(dir_up), 32'd1);
    check("se_peak", 32'(peak_count), 32'd0);
    feed(5, 0, '{4,5});
    check("se_peak_after", 32'(peak_count), 32'd1);
    check("se_dir_after", 32'(dir_up), 32'd0);

    // Reset mid-operation
    step(1, 0, 0, 0);
    feed(3, 0, '{0,1,2,3,2});
    step(1, 0, 0, 3);
    check("mr_peak0", 32'(peak_count), 32'd0);
    check("mr_dir0", 32'(dir_up), 32'd0);
    check("mr_pwm0", 32'(pwm_out), 32'd0);
    pv_seen = 0;
    feed(3, 0, '{0,1,2,3,2,1,0});
    check("mr_peak", 32'(peak_count), 32'd1);
    check("mr_no_pv", 32'(pv_seen), 32'd0);

    // Degenerate max=0
    step(1, 0, 0, 0);
    pv_seen = 0;
    feed(0, 0, '{0,0,0});
    check("deg_err0", 32'(step_err), 32'd0);
    check("deg_events", 32'(pv_seen) + 32'(peak_count), 32'd0);
    feed(0, 0, '{1});
    check("deg_err1", 32'(step_err), 32'd1);

    // PWM duty
    pwm_test(4);
    pwm_test(0);
    pwm_test(15);
    pwm_test(int'($urandom_range(1, 14)));

    // Randomized stream
    step(1, 0, 0, 0);
    mx = 6; g = 0; gd = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        step(1, 0, 0, mx);
        g = 0; gd = 1;
        continue;
      end
      if ($urandom_range(299) == 0) begin
        mx = $urandom_range(15);
        if (g > mx) g = mx;
      end
      if ($urandom_range(3) == 0) begin
        step(0, 0, $urandom_range(15), mx);
        continue;
      end
      if ($urandom_range(29) == 0) begin
        g = $urandom_range(15);
        if (g > mx) g = mx;
        gd = ($urandom_range(1) == 0) ? 1 : -1;
        step(0, 1, $urandom_range(15), mx);
        continue;
      end
      if (mx == 0) g = 0;
      else begin
        if (g + gd > mx || g + gd < 0) gd = -gd;
        g = g + gd;
      end
      step(0, 1, g, mx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
